uart_massiv_echo_ctrl: RTL and testbench
========================================

Name: uart_massiv_echo_ctrl

Overview:
- Hardware echo controller between the RX side and TX side of UART_TX_RX_MASSIV_MODULE.
- Waits until the RX buffer holds at least ECHO_THRESHOLD packs, then copies them to the TX massiv.
- Clears the RX buffer, launches transmission, and waits for TX completion.
- Replaces the testbench-driven loopback sequence with synthesizable control; used for link self-test and loopback.

Parameters:
- NUM_OF_DATA_BITS_IN_PACK, 5, bits per pack.
- RX_MASSIV_DEEP, 4, RX buffer depth in packs.
- TX_MASSIV_DEEP, 2, TX buffer depth in packs.
- ECHO_THRESHOLD, 2, ready-pack count that triggers an echo; legal range 1..RX_MASSIV_DEEP.
- SETTLE_CYCLES, 5, clocks to wait after the threshold is reached before capture.
- PULSE_CYCLES, 10, width in clocks of the clear and launch pulses.
- DONE_TIMEOUT_CYCLES, 65535, watchdog limit (used only with the optional feature).
- RXL = $clog2(RX_MASSIV_DEEP) and TXL = $clog2(TX_MASSIV_DEEP) are derived localparams.

Ports:
- IN_CLOCK  in  1  system clock.
- IN_RESET_N  in  1  asynchronous active-low reset.
- IN_ENABLE  in  1  permits starting a new echo.
- IN_RX_DATA_MASSIV  in  NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP  RX packs; pack 0 in the LSBs.
- IN_RX_NUM_OF_DATA_PACKS_READY  in  RXL+1  count of valid RX packs.
- IN_RX_ERROR  in  RXL+1  RX error field; nonzero means error.
- IN_TX_ACTIVE  in  1  TX busy.
- IN_TX_DONE  in  1  TX finished.
- OUT_TX_DATA_MASSIV  out  NUM_OF_DATA_BITS_IN_PACK*TX_MASSIV_DEEP  captured packs.
- OUT_TX_NUMBER_OF_PACKS_TO_SEND  out  TXL+1  number of packs to send.
- OUT_TX_LAUNCH  out  1  launch pulse.
- OUT_RX_CLEAR_BUFFER  out  1  RX clear pulse.
- OUT_BUSY  out  1  high in every state except IDLE.
- OUT_ECHO_COUNT  out  8  completed echoes, saturating at 255.
- OUT_DROP_COUNT  out  8  dropped (errored) batches, saturating at 255.

Behaviour:
- Reset (asynchronous, active-low) drives:
  - every output to 0;
  - the FSM to IDLE;
  - all internal counters to 0, including the done_prev register.
- Reset asserted mid-operation aborts the sequence immediately.
- FSM states: IDLE, SETTLE, CAPTURE, CLEAR, LAUNCH, WAIT_DONE.
- IDLE
  - Go to SETTLE when IN_ENABLE=1 and IN_RX_NUM_OF_DATA_PACKS_READY >= ECHO_THRESHOLD.
  - Start the settle counter at 0.
- SETTLE
  - Count SETTLE_CYCLES clocks, then go to CAPTURE.
  - If the ready count falls below ECHO_THRESHOLD at any point, return to IDLE without any action.
- CAPTURE (one cycle)
  - Register OUT_TX_DATA_MASSIV = the low NUM_OF_DATA_BITS_IN_PACK*TX_MASSIV_DEEP bits of IN_RX_DATA_MASSIV.
  - Register OUT_TX_NUMBER_OF_PACKS_TO_SEND = min(ready count, TX_MASSIV_DEEP).
  - Set an internal drop flag = (IN_RX_ERROR != 0).
  - Go to CLEAR.
- CLEAR
  - Hold OUT_RX_CLEAR_BUFFER=1 for exactly PULSE_CYCLES clocks; it falls on the last of them.
  - Then, if the drop flag is set: increment OUT_DROP_COUNT and return to IDLE; no launch is issued.
  - Otherwise go to LAUNCH.
- LAUNCH
  - Hold OUT_TX_LAUNCH=1 for exactly PULSE_CYCLES clocks, then go to WAIT_DONE.
  - Capture done_prev = IN_TX_DONE.
- WAIT_DONE
  - Exit on a rising edge of IN_TX_DONE (registered compare against the previous value).
  - On exit: increment OUT_ECHO_COUNT and go to IDLE.
  - A DONE that is already high and stays high does not count as completion.
- Latency: from the threshold being met to the clear rising edge is SETTLE_CYCLES+2 clocks.
- OUT_TX_DATA_MASSIV and OUT_TX_NUMBER_OF_PACKS_TO_SEND keep their values until the next CAPTURE.
- IN_ENABLE is sampled only in IDLE; deasserting it mid-sequence does not abort.
- The clear and launch pulses never overlap; there is at least one cycle gap (the state transition).
- Both counters saturate at 255 and never wrap.

Optional Feature:
- Macro: UART_ECHO_TIMEOUT_EN.
- Defined:
  - WAIT_DONE runs a 16-bit watchdog.
  - After DONE_TIMEOUT_CYCLES clocks without a rising edge of IN_TX_DONE: increment OUT_DROP_COUNT and go to IDLE.
  - OUT_ECHO_COUNT does not increment on timeout.
- Undefined: no watchdog; WAIT_DONE waits indefinitely.

Decomposition:
- Shared package uart_massiv_pkg holds:
  - the state enum echo_state_t;
  - the counter width constant ECHO_CNT_W=8;
  - the saturating-increment function.
- One sub-module, uart_pulse_gen:
  - loadable down-counter;
  - emits a level of PULSE_CYCLES length;
  - one instance each for clear and launch.

Test Plan:
- Send 2 packs 0x0A,0x13 (massiv 10'b1001101010), ready=2, no error → after 5 clocks settle: clear for 10 clocks, launch for 10 clocks, OUT_TX_DATA_MASSIV=10'b1001101010, packs_to_send=2; DONE pulse → OUT_ECHO_COUNT=1.
- ready=4 with TX_MASSIV_DEEP=2 → packs_to_send=2, only the low 10 bits copied.
- IN_RX_ERROR=1 at capture → clear pulse issued, no launch, OUT_DROP_COUNT=1, FSM back in IDLE.
- Ready count drops to 1 during SETTLE → no clear, no launch, OUT_BUSY low the next cycle.
- IN_RESET_N low in LAUNCH at cycle 4 → OUT_TX_LAUNCH=0 asynchronously; after release, FSM in IDLE and counters at 0.
- With UART_ECHO_TIMEOUT_EN and DONE_TIMEOUT_CYCLES=100 and DONE never asserted → IDLE after 100 clocks in WAIT_DONE, OUT_DROP_COUNT=1, OUT_ECHO_COUNT=0.

Source files
------------

// File: rtl/uart_massiv_pkg.sv
// Shared types and helpers for the UART massiv echo controller.
package uart_massiv_pkg;

  localparam int ECHO_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    CLEAR,
    LAUNCH,
    WAIT_DONE
  } echo_state_t;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [ECHO_CNT_W-1:0] sat_inc(input logic [ECHO_CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/uart_pulse_gen.sv
// Loadable down-counter that holds its output high for PULSE_CYCLES clocks after a load.
module uart_pulse_gen #(
  parameter int PULSE_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic pulse,
  output logic last
);

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (load) begin
      cnt   <= CW'(PULSE_CYCLES - 1);
      pulse <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      pulse <= 1'b0;
    end
  end

  // High during the final cycle of the pulse so the owner can move on as it drops.
  assign last = pulse && (cnt == '0);

endmodule

// File: rtl/uart_massiv_echo_ctrl.sv
// Echo controller: copies ready RX packs into the TX massiv, clears RX, launches TX and waits for done.
// Optional TX-done watchdog enabled by defining UART_ECHO_TIMEOUT_EN.
module uart_massiv_echo_ctrl
  import uart_massiv_pkg::*;
#(
  parameter int NUM_OF_DATA_BITS_IN_PACK = 5,
  parameter int RX_MASSIV_DEEP           = 4,
  parameter int TX_MASSIV_DEEP           = 2,
  parameter int ECHO_THRESHOLD           = 2,
  parameter int SETTLE_CYCLES            = 5,
  parameter int PULSE_CYCLES             = 10,
  parameter int DONE_TIMEOUT_CYCLES      = 65535,
  localparam int RXL = $clog2(RX_MASSIV_DEEP),
  localparam int TXL = $clog2(TX_MASSIV_DEEP)
) (
  input  logic                                               IN_CLOCK,
  input  logic                                               IN_RESET_N,
  input  logic                                               IN_ENABLE,
  input  logic [NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP-1:0] IN_RX_DATA_MASSIV,
  input  logic [RXL:0]                                       IN_RX_NUM_OF_DATA_PACKS_READY,
  input  logic [RXL:0]                                       IN_RX_ERROR,
  input  logic                                               IN_TX_ACTIVE,
  input  logic                                               IN_TX_DONE,
  output logic [NUM_OF_DATA_BITS_IN_PACK*TX_MASSIV_DEEP-1:0] OUT_TX_DATA_MASSIV,
  output logic [TXL:0]                                       OUT_TX_NUMBER_OF_PACKS_TO_SEND,
  output logic                                               OUT_TX_LAUNCH,
  output logic                                               OUT_RX_CLEAR_BUFFER,
  output logic                                               OUT_BUSY,
  output logic [ECHO_CNT_W-1:0]                              OUT_ECHO_COUNT,
  output logic [ECHO_CNT_W-1:0]                              OUT_DROP_COUNT
);

  localparam int TX_W = NUM_OF_DATA_BITS_IN_PACK * TX_MASSIV_DEEP;
  localparam int TXW  = TXL + 1;
  localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  echo_state_t   state;
  logic [SW-1:0] settle_cnt;
  logic          drop;
  logic          done_prev;
  logic          launch_load;
  logic          clear_load;
  logic          clear_last;
  logic          launch_last;
  logic          ready_ok;
  logic [TXW-1:0] n_send;
  logic          unused_sig;
`ifdef UART_ECHO_TIMEOUT_EN
  logic [15:0]   wd_cnt;
`endif

  assign ready_ok   = int'(IN_RX_NUM_OF_DATA_PACKS_READY) >= ECHO_THRESHOLD;
  assign clear_load = (state == CAPTURE);
  assign OUT_BUSY   = (state != IDLE);
  assign unused_sig = ^{IN_TX_ACTIVE, IN_RX_DATA_MASSIV, 32'(DONE_TIMEOUT_CYCLES)};

  always_comb begin
    n_send = TXW'(IN_RX_NUM_OF_DATA_PACKS_READY);
    if (int'(IN_RX_NUM_OF_DATA_PACKS_READY) >= TX_MASSIV_DEEP)
      n_send = TXW'(TX_MASSIV_DEEP);
  end

  uart_pulse_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_clear_pulse (
    .clk   (IN_CLOCK),
    .rst_n (IN_RESET_N),
    .load  (clear_load),
    .pulse (OUT_RX_CLEAR_BUFFER),
    .last  (clear_last)
  );

  // Launch load is registered so one idle cycle always separates clear and launch.
  uart_pulse_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_launch_pulse (
    .clk   (IN_CLOCK),
    .rst_n (IN_RESET_N),
    .load  (launch_load),
    .pulse (OUT_TX_LAUNCH),
    .last  (launch_last)
  );

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state                          <= IDLE;
      settle_cnt                     <= '0;
      drop                           <= 1'b0;
      done_prev                      <= 1'b0;
      launch_load                    <= 1'b0;
      OUT_TX_DATA_MASSIV             <= '0;
      OUT_TX_NUMBER_OF_PACKS_TO_SEND <= '0;
      OUT_ECHO_COUNT                 <= '0;
      OUT_DROP_COUNT                 <= '0;
`ifdef UART_ECHO_TIMEOUT_EN
      wd_cnt                         <= '0;
`endif
    end else begin
      launch_load <= 1'b0;
      case (state)
        IDLE: begin
          if (IN_ENABLE && ready_ok) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!ready_ok)
            state <= IDLE;
          else if (settle_cnt == SW'(SETTLE_CYCLES - 1))
            state <= CAPTURE;
          else
            settle_cnt <= settle_cnt + 1'b1;
        end
        CAPTURE: begin
          OUT_TX_DATA_MASSIV             <= IN_RX_DATA_MASSIV[TX_W-1:0];
          OUT_TX_NUMBER_OF_PACKS_TO_SEND <= n_send;
          drop                           <= (IN_RX_ERROR != '0);
          state                          <= CLEAR;
        end
        CLEAR: begin
          if (clear_last) begin
            if (drop) begin
              OUT_DROP_COUNT <= sat_inc(OUT_DROP_COUNT);
              state          <= IDLE;
            end else begin
              launch_load <= 1'b1;
              state       <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          done_prev <= IN_TX_DONE;
          if (launch_last) begin
            state <= WAIT_DONE;
`ifdef UART_ECHO_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        WAIT_DONE: begin
          // Only a fresh rising edge of done counts; a level left over from before is ignored.
          done_prev <= IN_TX_DONE;
          if (IN_TX_DONE && !done_prev) begin
            OUT_ECHO_COUNT <= sat_inc(OUT_ECHO_COUNT);
            state          <= IDLE;
          end
`ifdef UART_ECHO_TIMEOUT_EN
          else if (wd_cnt == 16'(DONE_TIMEOUT_CYCLES - 1)) begin
            OUT_DROP_COUNT <= sat_inc(OUT_DROP_COUNT);
            state          <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_massiv_echo_ctrl.sv
// Directed self-checking bench for uart_massiv_echo_ctrl (watchdog limit set to 100 for the timeout case).
module tb_uart_massiv_echo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable;
  logic [19:0] rx_data;
  logic [2:0]  ready;
  logic [2:0]  rx_err;
  logic        tx_active;
  logic        tx_done;
  logic [9:0]  tx_data;
  logic [1:0]  packs;
  logic        launch;
  logic        clear;
  logic        busy;
  logic [7:0]  echo_cnt;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int w;
  logic seen;

  always #5 clk = ~clk;

  uart_massiv_echo_ctrl #(.DONE_TIMEOUT_CYCLES(100)) dut (
    .IN_CLOCK                       (clk),
    .IN_RESET_N                     (rst_n),
    .IN_ENABLE                      (enable),
    .IN_RX_DATA_MASSIV              (rx_data),
    .IN_RX_NUM_OF_DATA_PACKS_READY  (ready),
    .IN_RX_ERROR                    (rx_err),
    .IN_TX_ACTIVE                   (tx_active),
    .IN_TX_DONE                     (tx_done),
    .OUT_TX_DATA_MASSIV             (tx_data),
    .OUT_TX_NUMBER_OF_PACKS_TO_SEND (packs),
    .OUT_TX_LAUNCH                  (launch),
    .OUT_RX_CLEAR_BUFFER            (clear),
    .OUT_BUSY                       (busy),
    .OUT_ECHO_COUNT                 (echo_cnt),
    .OUT_DROP_COUNT                 (drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] rdy, input logic [2:0] err,
                               input logic [19:0] data, input logic done);
    enable    = en;
    ready     = rdy;
    rx_err    = err;
    rx_data   = data;
    tx_done   = done;
    tx_active = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts consecutive high cycles of clear (sel=0) or launch (sel=1), bounded at 40.
  task automatic measureWidth(input int sel, output int width);
    width = 0;
    while (((sel == 0) ? clear : launch) && width < 40) begin
      width++;
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1'b0, 3'd0, 3'd0, 20'd0, 1'b0);
    tick(2);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clear", clear, 0);
    checkOutput("rst_launch", launch, 0);
    checkOutput("rst_echo", echo_cnt, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    checkOutput("rst_data", tx_data, 0);
    checkOutput("rst_packs", packs, 0);
    rst_n = 1'b1;
    tick(1);

    // Basic echo of packs 0x0A,0x13
    applyStimulus(1'b1, 3'd2, 3'd0, {10'b1111100000, 10'b1001101010}, 1'b0);
    tick(1);
    checkOutput("t1_busy", busy, 1);
    tick(5);
    checkOutput("t1_clr_latency", clear, 0);
    tick(1);
    checkOutput("t1_clr_rise", clear, 1);
    checkOutput("t1_data", tx_data, 10'b1001101010);
    checkOutput("t1_packs", packs, 2);
    enable = 1'b0;
    measureWidth(0, w);
    checkOutput("t1_clr_width", w, 10);
    checkOutput("t1_gap", launch, 0);
    tick(1);
    checkOutput("t1_launch_rise", launch, 1);
    measureWidth(1, w);
    checkOutput("t1_launch_width", w, 10);
    checkOutput("t1_wait_busy", busy, 1);
    tick(5);
    checkOutput("t1_still_waiting", busy, 1);
    checkOutput("t1_echo_before", echo_cnt, 0);
    tx_done = 1'b1;
    tick(1);
    checkOutput("t1_echo", echo_cnt, 1);
    checkOutput("t1_idle", busy, 0);
    tx_done = 1'b0;

    // ready=4 limits packs to TX depth and copies only the low 10 bits
    applyStimulus(1'b1, 3'd4, 3'd0, {10'b0101010101, 10'b0110010101}, 1'b0);
    tick(7);
    checkOutput("t2_clr_rise", clear, 1);
    checkOutput("t2_data", tx_data, 10'b0110010101);
    checkOutput("t2_packs", packs, 2);
    enable = 1'b0;
    measureWidth(0, w);
    tick(1);
    checkOutput("t2_launch_rise", launch, 1);
    measureWidth(1, w);
    tick(2);
    tx_done = 1'b1;
    tick(1);
    checkOutput("t2_echo", echo_cnt, 2);
    tx_done = 1'b0;

    // RX error: clear only, no launch, drop counted
    applyStimulus(1'b1, 3'd3, 3'd1, {10'b0, 10'b0000111110}, 1'b0);
    tick(7);
    checkOutput("t3_clr_rise", clear, 1);
    checkOutput("t3_data", tx_data, 10'b0000111110);
    enable = 1'b0;
    measureWidth(0, w);
    checkOutput("t3_clr_width", w, 10);
    checkOutput("t3_no_launch", launch, 0);
    checkOutput("t3_idle", busy, 0);
    checkOutput("t3_drop", drop_cnt, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | launch;
    end
    checkOutput("t3_launch_never", seen, 0);
    checkOutput("t3_echo_same", echo_cnt, 2);

    // Ready count falls during SETTLE
    applyStimulus(1'b1, 3'd2, 3'd0, 20'h12345, 1'b0);
    tick(3);
    checkOutput("t4_settling", busy, 1);
    applyStimulus(1'b0, 3'd1, 3'd0, 20'h12345, 1'b0);
    tick(1);
    checkOutput("t4_abort_idle", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | clear | launch;
    end
    checkOutput("t4_no_pulses", seen, 0);
    checkOutput("t4_drop_same", drop_cnt, 1);

    // Asynchronous reset during LAUNCH cycle 4
    applyStimulus(1'b1, 3'd2, 3'd0, {10'b0, 10'b1010101010}, 1'b0);
    tick(7);
    enable = 1'b0;
    measureWidth(0, w);
    tick(1);
    checkOutput("t5_launch_rise", launch, 1);
    tick(3);
    checkOutput("t5_launch_c4", launch, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_launch", launch, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_echo", echo_cnt, 0);
    checkOutput("t5_rst_drop", drop_cnt, 0);
    checkOutput("t5_rst_data", tx_data, 0);
    checkOutput("t5_rst_packs", packs, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(3);
    checkOutput("t5_post_idle", busy, 0);
    checkOutput("t5_post_launch", launch, 0);

    // DONE already high through launch: not a completion
    applyStimulus(1'b1, 3'd2, 3'd0, {10'b0, 10'b0000000001}, 1'b1);
    tick(7);
    enable = 1'b0;
    measureWidth(0, w);
    tick(1);
    checkOutput("t6_launch_rise", launch, 1);
    measureWidth(1, w);
`ifdef UART_ECHO_TIMEOUT_EN
    tick(99);
    checkOutput("t6_wd_waiting", busy, 1);
    tick(1);
    checkOutput("t6_wd_idle", busy, 0);
    checkOutput("t6_wd_drop", drop_cnt, 1);
    checkOutput("t6_wd_echo", echo_cnt, 0);
`else
    tick(120);
    checkOutput("t6_held_done_wait", busy, 1);
    checkOutput("t6_held_done_echo", echo_cnt, 0);
    tx_done = 1'b0;
    tick(2);
    checkOutput("t6_low_wait", busy, 1);
    tx_done = 1'b1;
    tick(1);
    checkOutput("t6_rise_idle", busy, 0);
    checkOutput("t6_rise_echo", echo_cnt, 1);
    checkOutput("t6_drop_zero", drop_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
